// File: rtl/alu_seq.sv
// Sequencer that issues one operation to an external 8-bit ALU, waits for it to settle,
// then captures the result and N/Z/C/V status flags.
module alu_seq #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic       req_carry_in,
    input  logic       req_use_c,
    output logic [2:0] alu_control,
    output logic [7:0] alu_AI,
    output logic [7:0] alu_BI,
    output logic       alu_carry_in,
    input  logic [7:0] alu_Y,
    input  logic       alu_carry_out,
    input  logic       alu_overflow,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_Y,
    output logic       p_N,
    output logic       p_Z,
    output logic       p_C,
    output logic       p_V,
    input  logic       flag_wr,
    input  logic [3:0] flag_wdata
);

    localparam logic [2:0] OP_ADD   = 3'd3;
    localparam logic [2:0] OP_SR    = 3'd4;
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next;
    logic [3:0] flags, flags_next, flags_in;
    logic [7:0] rsp_y_next, ai_next, bi_next;
    logic [2:0] ctl_next;
    logic       cin_next, ready_next, valid_next;

    assign p_N = flags[3];
    assign p_Z = flags[2];
    assign p_C = flags[1];
    assign p_V = flags[0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            cnt          <= '0;
            flags        <= '0;
            rsp_Y        <= '0;
            rsp_valid    <= 1'b0;
            req_ready    <= 1'b1;
            alu_control  <= '0;
            alu_AI       <= '0;
            alu_BI       <= '0;
            alu_carry_in <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            flags        <= flags_next;
            rsp_Y        <= rsp_y_next;
            rsp_valid    <= valid_next;
            req_ready    <= ready_next;
            alu_control  <= ctl_next;
            alu_AI       <= ai_next;
            alu_BI       <= bi_next;
            alu_carry_in <= cin_next;
        end
    end

    // A direct flag load in the same cycle as an accept feeds its C into a use_c request.
    assign flags_in = flag_wr ? flag_wdata : flags;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        flags_next = flags;
        rsp_y_next = rsp_Y;
        valid_next = rsp_valid;
        ready_next = req_ready;
        ctl_next   = alu_control;
        ai_next    = alu_AI;
        bi_next    = alu_BI;
        cin_next   = alu_carry_in;

        case (state)
            IDLE: begin
                flags_next = flags_in;
                if (req_valid && req_ready) begin
                    ctl_next   = req_op;
                    ai_next    = req_a;
                    bi_next    = req_b;
                    cin_next   = req_use_c ? flags_in[1] : req_carry_in;
                    cnt_next   = CNT_LOAD;
                    ready_next = 1'b0;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt == 4'd0) begin
                    rsp_y_next    = alu_Y;
                    flags_next[3] = alu_Y[7];
                    flags_next[2] = (alu_Y == 8'd0);
                    if (alu_control == OP_ADD) begin
                        flags_next[1] = alu_carry_out;
                        flags_next[0] = alu_overflow;
                    end else if (alu_control == OP_SR) begin
                        flags_next[1] = alu_carry_out;
                    end
                    valid_next = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    valid_next = 1'b0;
                    ready_next = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
